// File: rtl/gpu_pkg.sv
// Shared dispatcher types: FSM state encoding, block-index / thread-count widths, popcount helper.
package gpu_pkg;

   localparam int unsigned BLK_IDX_W = 8;
   localparam int unsigned THR_CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } disp_state_t;

   // Number of set bits in a (zero-extended) core mask.
   function automatic logic [BLK_IDX_W-1:0] popcount32(input logic [31:0] v);
      logic [BLK_IDX_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + BLK_IDX_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/dispatch_arbiter.sv
// Combinational lowest-index-first selector over eligible cores (one-hot grant + valid).
module dispatch_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant_c,
   output logic         o_valid_c
);

   // First set request bit wins.
   always_comb begin
      o_grant_c = '0;
      o_valid_c = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (i_req[i] && !o_valid_c) begin
            o_grant_c[i] = 1'b1;
            o_valid_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: splits thread_count into blocks and hands them to free cores,
// recycling cores on done and raising done when every block has completed.
// Optional macro DISPATCH_PERF_EN builds the saturating busy_cycles counter (else constant 0).
module block_dispatcher
   import gpu_pkg::*;
#(
   parameter  int unsigned NUM_CORES         = 2,
   parameter  int unsigned THREADS_PER_BLOCK = 4,
   localparam int unsigned TCW               = $clog2(THREADS_PER_BLOCK) + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [THR_CNT_W-1:0]           thread_count,
   input  logic [NUM_CORES-1:0]           core_done,
   output logic [NUM_CORES-1:0]           core_start,
   output logic [NUM_CORES-1:0]           core_reset,
   output logic [NUM_CORES*BLK_IDX_W-1:0] core_block_id,
   output logic [NUM_CORES*TCW-1:0]       core_thread_count,
   output logic                           done,
   output logic [31:0]                    busy_cycles
);

   localparam int unsigned TPB_SHIFT = $clog2(THREADS_PER_BLOCK);

   disp_state_t                    r_state,        w_state_nxt;
   logic [BLK_IDX_W-1:0]           r_total_blocks, w_total_blocks_nxt;
   logic [BLK_IDX_W-1:0]           r_blocks_disp,  w_blocks_disp_nxt;
   logic [BLK_IDX_W-1:0]           r_blocks_done,  w_blocks_done_nxt;
   logic [THR_CNT_W-1:0]           r_thread_count, w_thread_count_nxt;
   logic [NUM_CORES-1:0]           r_core_start,   w_core_start_nxt;
   logic [NUM_CORES-1:0]           r_core_reset,   w_core_reset_nxt;
   logic [NUM_CORES*BLK_IDX_W-1:0] r_block_id,     w_block_id_nxt;
   logic [NUM_CORES*TCW-1:0]       r_thr_cnt,      w_thr_cnt_nxt;
   logic                           r_done,         w_done_nxt;

   logic [NUM_CORES-1:0] w_req;
   logic [NUM_CORES-1:0] w_grant;
   logic                 w_grant_valid;
   logic [NUM_CORES-1:0] w_complete;
   logic [8:0]           w_tot9;
   logic [15:0]          w_rem;
   logic [TCW-1:0]       w_blk_cnt;

   // Free cores are eligible only while blocks remain to be handed out.
   assign w_req = (r_state == S_RUN && r_blocks_disp < r_total_blocks) ? r_core_reset : '0;

   // Cores finishing this edge: only those actually running a block.
   assign w_complete = r_core_start & core_done;

   // ceil(thread_count / TPB) with 9-bit headroom.
   assign w_tot9 = (9'(thread_count) + 9'(THREADS_PER_BLOCK - 1)) >> TPB_SHIFT;

   // Thread count for the block being dispatched; the last block gets the remainder.
   assign w_rem     = 16'(r_thread_count) - (16'(r_blocks_disp) * 16'(THREADS_PER_BLOCK));
   assign w_blk_cnt = (r_blocks_disp == r_total_blocks - 8'd1) ? TCW'(w_rem)
                                                               : TCW'(THREADS_PER_BLOCK);

   dispatch_arbiter #(
      .N (NUM_CORES)
   ) u_arb (
      .i_req     (w_req),
      .o_grant_c (w_grant),
      .o_valid_c (w_grant_valid)
   );

   // Next-state and next-output logic for the dispatcher FSM.
   always_comb begin
      w_state_nxt        = r_state;
      w_total_blocks_nxt = r_total_blocks;
      w_blocks_disp_nxt  = r_blocks_disp;
      w_blocks_done_nxt  = r_blocks_done;
      w_thread_count_nxt = r_thread_count;
      w_core_start_nxt   = r_core_start;
      w_core_reset_nxt   = r_core_reset;
      w_block_id_nxt     = r_block_id;
      w_thr_cnt_nxt      = r_thr_cnt;
      w_done_nxt         = r_done;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt        = S_RUN;
               w_total_blocks_nxt = 8'(w_tot9);
               w_thread_count_nxt = thread_count;
               w_blocks_disp_nxt  = '0;
               w_blocks_done_nxt  = '0;
            end
         end
         S_RUN: begin
            w_core_start_nxt  = r_core_start & ~w_complete;
            w_core_reset_nxt  = r_core_reset | w_complete;
            w_blocks_done_nxt = r_blocks_done + popcount32(32'(w_complete));
            if (w_grant_valid) begin
               for (int i = 0; i < int'(NUM_CORES); i++) begin
                  if (w_grant[i]) begin
                     w_core_reset_nxt[i]                       = 1'b0;
                     w_core_start_nxt[i]                       = 1'b1;
                     w_block_id_nxt[i*BLK_IDX_W +: BLK_IDX_W]  = r_blocks_disp;
                     w_thr_cnt_nxt[i*TCW +: TCW]               = w_blk_cnt;
                  end
               end
               w_blocks_disp_nxt = r_blocks_disp + 8'd1;
            end
            if (w_blocks_done_nxt == r_total_blocks) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end
         end
         S_DONE: begin
            if (!start) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset holds every core in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_total_blocks <= '0;
         r_blocks_disp  <= '0;
         r_blocks_done  <= '0;
         r_thread_count <= '0;
         r_core_start   <= '0;
         r_core_reset   <= '1;
         r_block_id     <= '0;
         r_thr_cnt      <= '0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_total_blocks <= w_total_blocks_nxt;
         r_blocks_disp  <= w_blocks_disp_nxt;
         r_blocks_done  <= w_blocks_done_nxt;
         r_thread_count <= w_thread_count_nxt;
         r_core_start   <= w_core_start_nxt;
         r_core_reset   <= w_core_reset_nxt;
         r_block_id     <= w_block_id_nxt;
         r_thr_cnt      <= w_thr_cnt_nxt;
         r_done         <= w_done_nxt;
      end
   end

`ifdef DISPATCH_PERF_EN
   logic [31:0] r_busy;

   // Saturating count of RUN edges; cleared at launch, held in IDLE/DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_busy <= '0;
      end else if (r_state == S_RUN && r_busy != 32'hFFFF_FFFF) begin
         r_busy <= r_busy + 32'd1;
      end
   end

   assign busy_cycles = r_busy;
`else
   assign busy_cycles = '0;
`endif

   assign core_start        = r_core_start;
   assign core_reset        = r_core_reset;
   assign core_block_id     = r_block_id;
   assign core_thread_count = r_thr_cnt;
   assign done              = r_done;

endmodule
